prf_multiport: RTL

PRF_MULTIPORT -- requirements
Module: prf_multiport

---
 rtl/rv32i_types.sv | 5 +
 rtl/prf_read_port.sv | 45 ++++
 rtl/prf_multiport.sv | 92 +++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared PRF constants and read-port state encoding.
package rv32i_types;
    localparam int PRF_DATA_W = 32;
    typedef enum logic {IDLE, HOLD} prf_port_state_t;
endpackage

// File: rtl/prf_read_port.sv
// prf_read_port: one operand read port; captures an rs1/rs2 pair and holds it until acknowledged.
module prf_read_port
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_req,
    input  logic                  i_ack,
    input  logic [PRF_DATA_W-1:0] i_rs1_val,
    input  logic [PRF_DATA_W-1:0] i_rs2_val,
    output logic                  o_ready,
    output logic                  o_op_v,
    output logic [PRF_DATA_W-1:0] o_rs1_val,
    output logic [PRF_DATA_W-1:0] o_rs2_val
);
    prf_port_state_t       r_state;
    logic                  r_op_v;
    logic [PRF_DATA_W-1:0] r_rs1, r_rs2;
    logic                  w_take;

    // A held slot frees up in the same cycle it is acknowledged, allowing one op per cycle.
    assign o_ready   = (r_state == IDLE) || i_ack;
    assign w_take    = i_req && o_ready;
    assign o_op_v    = r_op_v;
    assign o_rs1_val = r_rs1;
    assign o_rs2_val = r_rs2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= IDLE;
            r_op_v  <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else if (w_take) begin
            r_state <= HOLD;
            r_op_v  <= 1'b1;
            r_rs1   <= i_rs1_val;
            r_rs2   <= i_rs2_val;
        end else if (r_state == HOLD && i_ack) begin
            r_state <= IDLE;
            r_op_v  <= 1'b0;
        end
    end
endmodule

// File: rtl/prf_multiport.sv
// prf_multiport: multi-write physical register file with ready bits and held-operand read ports.
// Define PRF_BYPASS_EN to forward same-cycle write data into operand captures.
module prf_multiport
    import rv32i_types::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int NUM_WR        = 3,
    parameter int NUM_RD        = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic                                        alloc_v,
    input  logic [PHYS_REG_BITS-1:0]                    alloc_preg,
    input  logic [NUM_WR-1:0]                           wr_v,
    input  logic [NUM_WR-1:0][PHYS_REG_BITS-1:0]        wr_preg,
    input  logic [NUM_WR-1:0][4:0]                      wr_arch_rd,
    input  logic [NUM_WR-1:0][PRF_DATA_W-1:0]           wr_data,
    input  logic [NUM_RD-1:0]                           rd_req,
    input  logic [NUM_RD-1:0][PHYS_REG_BITS-1:0]        rd_rs1,
    input  logic [NUM_RD-1:0][PHYS_REG_BITS-1:0]        rd_rs2,
    output logic [NUM_RD-1:0]                           rd_ready,
    output logic [NUM_RD-1:0]                           op_v,
    output logic [NUM_RD-1:0][PRF_DATA_W-1:0]           op_rs1_v,
    output logic [NUM_RD-1:0][PRF_DATA_W-1:0]           op_rs2_v,
    input  logic [NUM_RD-1:0]                           op_ack,
    output logic [2**PHYS_REG_BITS-1:0]                 preg_rdy
);
    localparam int DEPTH = 2**PHYS_REG_BITS;

    logic [PRF_DATA_W-1:0]              r_regs [DEPTH];
    logic [DEPTH-1:0]                   r_rdy;
    logic [NUM_WR-1:0]                  w_wr_en;
    logic [NUM_WR-1:0][PRF_DATA_W-1:0]  w_wr_val;
    logic [NUM_RD-1:0][PRF_DATA_W-1:0]  w_rs1_val, w_rs2_val;

    assign preg_rdy = r_rdy;

    // Writes to p0 are dropped, so p0 keeps its reset value of zero; arch rd x0 stores zero.
    always_comb
        for (int i = 0; i < NUM_WR; i++) begin
            w_wr_en[i]  = wr_v[i] && (wr_preg[i] != '0);
            w_wr_val[i] = (wr_arch_rd[i] == 5'd0) ? '0 : wr_data[i];
        end

    function automatic logic [PRF_DATA_W-1:0] f_read(input logic [PHYS_REG_BITS-1:0] p);
        logic [PRF_DATA_W-1:0] v;
        v = r_regs[p];
`ifdef PRF_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++)
            if (w_wr_en[i] && wr_preg[i] == p) v = w_wr_val[i];
`endif
        return v;
    endfunction

    always_comb
        for (int i = 0; i < NUM_RD; i++) begin
            w_rs1_val[i] = f_read(rd_rs1[i]);
            w_rs2_val[i] = f_read(rd_rs2[i]);
        end

    // Ascending port order makes the highest write port win; the alloc clear comes last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_rdy <= '1;
        end else begin
            for (int i = 0; i < NUM_WR; i++)
                if (w_wr_en[i]) begin
                    r_regs[wr_preg[i]] <= w_wr_val[i];
                    r_rdy[wr_preg[i]]  <= 1'b1;
                end
            if (alloc_v && alloc_preg != '0) r_rdy[alloc_preg] <= 1'b0;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        prf_read_port u_port (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .i_req     (rd_req[r]),
            .i_ack     (op_ack[r]),
            .i_rs1_val (w_rs1_val[r]),
            .i_rs2_val (w_rs2_val[r]),
            .o_ready   (rd_ready[r]),
            .o_op_v    (op_v[r]),
            .o_rs1_val (op_rs1_v[r]),
            .o_rs2_val (op_rs2_v[r])
        );
    end
endmodule
